// File: rtl/axis_arb_pkg.sv
// Shared types and slice helpers for the AXI-stream packet arbiter.
package axis_arb_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_LOCK = 1'b1
    } state_t;

    // Bit offset of source s inside the flattened tdata bus.
    function automatic int data_off(input int s, input int ew);
        return s * (8 << ew);
    endfunction

    // Bit offset of source s inside the flattened tkeep bus.
    function automatic int keep_off(input int s, input int ew);
        return s * (1 << ew);
    endfunction

endpackage

// File: rtl/axis_arb_rr_pick.sv
// Combinational rotating-priority picker: first requester after ptr, with wrap.
// With AXIS_ARB_FIXED_PRIO_EN defined the search base is pinned so index 0 always wins first.
module axis_arb_rr_pick #(
    parameter int SW = 1
) (
    input  logic [(1<<SW)-1:0] req,
    input  logic [SW-1:0]      ptr,
    output logic [SW-1:0]      win,
    output logic               any
);
    localparam int NUM = 1 << SW;

    logic [SW-1:0] base;
    logic [SW-1:0] idx;

`ifdef AXIS_ARB_FIXED_PRIO_EN
    logic unused_ptr;
    assign unused_ptr = ^ptr;
    assign base       = SW'(NUM - 1);
`else
    assign base = ptr;
`endif

    // Walk from lowest to highest priority so the last hit is the winner.
    always_comb begin
        win = '0;
        idx = '0;
        any = |req;
        for (int k = NUM; k >= 1; k--) begin
            idx = base + SW'(k);
            if (req[idx]) win = idx;
        end
    end

endmodule

// File: rtl/axi_stream_packet_arbiter.sv
// Packet-granular arbiter sharing one registered AXI-stream output among 1<<SW sources.
// Define AXIS_ARB_FIXED_PRIO_EN for lowest-index-wins arbitration instead of round-robin.
module axi_stream_packet_arbiter
    import axis_arb_pkg::*;
#(
    parameter int SW = 1,
    parameter int EW = 0
) (
    input  logic                         rstn,
    input  logic                         clk,
    output logic [(1<<SW)-1:0]           i_tready,
    input  logic [(1<<SW)-1:0]           i_tvalid,
    input  logic [(1<<SW)*(8<<EW)-1:0]   i_tdata,
    input  logic [(1<<SW)*(1<<EW)-1:0]   i_tkeep,
    input  logic [(1<<SW)-1:0]           i_tlast,
    input  logic                         o_tready,
    output logic                         o_tvalid,
    output logic [(8<<EW)-1:0]           o_tdata,
    output logic [(1<<EW)-1:0]           o_tkeep,
    output logic                         o_tlast,
    output logic [SW-1:0]                o_tid,
    output logic                         o_busy
);
    localparam int NUM = 1 << SW;
    localparam int DW  = 8 << EW;
    localparam int KW  = 1 << EW;

    state_t        state;
    logic [SW-1:0] grant;
    logic [SW-1:0] ptr;
    logic [SW-1:0] win;
    logic          any;
    logic          out_free;
    logic          take;

    logic [DW-1:0] src_data [NUM];
    logic [KW-1:0] src_keep [NUM];

    for (genvar s = 0; s < NUM; s++) begin : g_slice
        assign src_data[s] = i_tdata[data_off(s, EW) +: DW];
        assign src_keep[s] = i_tkeep[keep_off(s, EW) +: KW];
    end

    axis_arb_rr_pick #(.SW(SW)) u_pick (
        .req (i_tvalid),
        .ptr (ptr),
        .win (win),
        .any (any)
    );

    // Output register accepts a beat when empty or being drained this cycle.
    assign out_free = o_tready | ~o_tvalid;
    assign take     = (state == ST_LOCK) & i_tvalid[grant] & out_free;

    always_comb begin
        i_tready = '0;
        if (state == ST_LOCK) i_tready[grant] = out_free;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state    <= ST_IDLE;
            o_busy   <= 1'b0;
            grant    <= '0;
            ptr      <= SW'(NUM - 1);
            o_tvalid <= 1'b0;
            o_tdata  <= '0;
            o_tkeep  <= '0;
            o_tlast  <= 1'b0;
            o_tid    <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (any) begin
                        grant  <= win;
`ifndef AXIS_ARB_FIXED_PRIO_EN
                        ptr    <= win;
`endif
                        state  <= ST_LOCK;
                        o_busy <= 1'b1;
                    end
                end
                ST_LOCK: begin
                    // The lock is released only by an accepted tlast beat.
                    if (take && i_tlast[grant]) begin
                        state  <= ST_IDLE;
                        o_busy <= 1'b0;
                    end
                end
                default: begin
                    state  <= ST_IDLE;
                    o_busy <= 1'b0;
                end
            endcase

            if (take) begin
                o_tvalid <= 1'b1;
                o_tdata  <= src_data[grant];
                o_tkeep  <= src_keep[grant];
                o_tlast  <= i_tlast[grant];
                o_tid    <= grant;
            end else if (o_tready) begin
                o_tvalid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_axi_stream_packet_arbiter.sv
// Directed bench: a wide (EW=2) and a narrow (EW=0) arbiter share the same stimulus and a cycle model.
module tb_axi_stream_packet_arbiter;
    localparam int SW  = 1;
    localparam int NUM = 2;
    localparam int DW  = 32;
    localparam int KW  = 4;

    typedef struct packed {
        logic [31:0] data;
        logic [3:0]  keep;
        logic        last;
    } beat_t;

    typedef struct {
        int          cyc;
        int          tid;
        logic [31:0] data;
        logic [3:0]  keep;
        logic        last;
    } log_t;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    logic [NUM-1:0]    i_tvalid = '0;
    logic [NUM-1:0]    i_tlast = '0;
    logic [NUM*DW-1:0] i_tdata = '0;
    logic [NUM*KW-1:0] i_tkeep = '0;
    logic              o_tready = 1'b1;

    logic [NUM-1:0] a_tready, b_tready;
    logic           a_tvalid, b_tvalid, a_tlast, b_tlast, a_busy, b_busy;
    logic [DW-1:0]  a_tdata;
    logic [7:0]     b_tdata;
    logic [KW-1:0]  a_tkeep;
    logic           b_tkeep;
    logic [SW-1:0]  a_tid, b_tid;
    logic [NUM*8-1:0] n_tdata;
    logic [NUM-1:0]   n_tkeep;

    assign n_tdata = {i_tdata[39:32], i_tdata[7:0]};
    assign n_tkeep = {i_tkeep[4], i_tkeep[0]};

    axi_stream_packet_arbiter #(.SW(SW), .EW(2)) dut_a (
        .rstn(rstn), .clk(clk), .i_tready(a_tready), .i_tvalid(i_tvalid),
        .i_tdata(i_tdata), .i_tkeep(i_tkeep), .i_tlast(i_tlast), .o_tready(o_tready),
        .o_tvalid(a_tvalid), .o_tdata(a_tdata), .o_tkeep(a_tkeep), .o_tlast(a_tlast),
        .o_tid(a_tid), .o_busy(a_busy)
    );

    axi_stream_packet_arbiter #(.SW(SW), .EW(0)) dut_b (
        .rstn(rstn), .clk(clk), .i_tready(b_tready), .i_tvalid(i_tvalid),
        .i_tdata(n_tdata), .i_tkeep(n_tkeep), .i_tlast(i_tlast), .o_tready(o_tready),
        .o_tvalid(b_tvalid), .o_tdata(b_tdata), .o_tkeep(b_tkeep), .o_tlast(b_tlast),
        .o_tid(b_tid), .o_busy(b_busy)
    );

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    bit cmp_en = 1'b0;

    beat_t q0[$];
    beat_t q1[$];
    logic [NUM-1:0] hold = '0;
    logic [NUM-1:0] hs_pend = '0;
    logic [37:0] exp_q[$];
    log_t log_q[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Spec-level model: who owns the output, who won last, and what the output register holds.
    int          m_lock = 0, m_grant = 0, m_last = NUM - 1;
    logic        m_ov = 1'b0, m_ol = 1'b0;
    logic [31:0] m_od = '0;
    logic [3:0]  m_ok = '0;
    int          m_ot = 0;
    bit          mt_take;
    int          mt_pick, mt_base, mt_s;

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            m_lock = 0; m_grant = 0; m_last = NUM - 1;
            m_ov = 1'b0; m_od = '0; m_ok = '0; m_ol = 1'b0; m_ot = 0;
            exp_q.delete();
        end else begin
            mt_take = (m_lock != 0) && i_tvalid[m_grant] && (o_tready || !m_ov);
            mt_pick = -1;
`ifdef AXIS_ARB_FIXED_PRIO_EN
            mt_base = NUM - 1;
`else
            mt_base = m_last;
`endif
            if (m_lock == 0) begin
                for (int k = 1; k <= NUM; k++) begin
                    mt_s = (mt_base + k) % NUM;
                    if (mt_pick < 0 && i_tvalid[mt_s]) mt_pick = mt_s;
                end
            end
            if (mt_take) begin
                m_ov = 1'b1;
                m_od = i_tdata[m_grant*DW +: DW];
                m_ok = i_tkeep[m_grant*KW +: KW];
                m_ol = i_tlast[m_grant];
                m_ot = m_grant;
                if (i_tlast[m_grant]) m_lock = 0;
            end else if (o_tready) begin
                m_ov = 1'b0;
            end
            if (mt_pick >= 0) begin
                m_lock = 1;
                m_grant = mt_pick;
                m_last = mt_pick;
            end
        end
    end

    // Compare process, beat scoreboard, output log and source handshake sampling.
    logic [NUM-1:0] er;
    logic [37:0]    sb;
    always @(negedge clk) begin
        if (cmp_en) begin
            er = '0;
            if (m_lock != 0 && (o_tready || !m_ov)) er[m_grant] = 1'b1;
            chk("a_tvalid", a_tvalid, m_ov);
            chk("a_busy", a_busy, m_lock != 0);
            chk("a_tready", a_tready, er);
            chk("a_tdata", a_tdata, m_od);
            chk("a_tkeep", a_tkeep, m_ok);
            chk("a_tlast", a_tlast, m_ol);
            chk("a_tid", a_tid, m_ot);
            chk("b_tvalid", b_tvalid, m_ov);
            chk("b_busy", b_busy, m_lock != 0);
            chk("b_tready", b_tready, er);
            chk("b_tdata", b_tdata, m_od[7:0]);
            chk("b_tkeep", b_tkeep, m_ok[0]);
            chk("b_tlast", b_tlast, m_ol);
            chk("b_tid", b_tid, m_ot);
            if (a_tvalid && o_tready) begin
                log_q.push_back('{cyc, int'(a_tid), a_tdata, a_tkeep, a_tlast});
                if (exp_q.size() == 0) begin
                    chk("sb_empty", exp_q.size(), 1);
                end else begin
                    sb = exp_q.pop_front();
                    chk("sb_beat", {a_tid, a_tdata, a_tkeep, a_tlast}, sb);
                end
            end
        end
        hs_pend = i_tvalid & a_tready;
        if (hs_pend[0]) exp_q.push_back({1'b0, q0[0].data, q0[0].keep, q0[0].last});
        if (hs_pend[1]) exp_q.push_back({1'b1, q1[0].data, q1[0].keep, q1[0].last});
    end

    task automatic present();
        i_tvalid = '0; i_tlast = '0; i_tdata = '0; i_tkeep = '0;
        if (q0.size() > 0 && !hold[0]) begin
            i_tvalid[0] = 1'b1; i_tdata[31:0] = q0[0].data;
            i_tkeep[3:0] = q0[0].keep; i_tlast[0] = q0[0].last;
        end
        if (q1.size() > 0 && !hold[1]) begin
            i_tvalid[1] = 1'b1; i_tdata[63:32] = q1[0].data;
            i_tkeep[7:4] = q1[0].keep; i_tlast[1] = q1[0].last;
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        if (hs_pend[0]) q0.delete(0);
        if (hs_pend[1]) q1.delete(0);
        present();
    endtask

    task automatic wait_beats(input int n, input int budget);
        int k;
        k = 0;
        while (log_q.size() < n && k < budget) begin
            step();
            k++;
        end
        chk("wait_beats_in_budget", log_q.size() >= n, 1'b1);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rstn = 1'b0;
        #1;
        chk("rst_a_tvalid", a_tvalid, 1'b0);
        chk("rst_a_busy", a_busy, 1'b0);
        chk("rst_a_tdata", a_tdata, 32'h0);
        chk("rst_a_tkeep", a_tkeep, 4'h0);
        chk("rst_a_tlast", a_tlast, 1'b0);
        chk("rst_a_tid", a_tid, 1'b0);
        chk("rst_a_tready", a_tready, 2'b00);
        chk("rst_b_tvalid", b_tvalid, 1'b0);
        step();
        step();
        rstn = 1'b1;
        log_q.delete();
    endtask

    task automatic chk_entry(input string tag, input int idx, input int tid,
                             input logic [31:0] data, input logic [3:0] keep, input logic last);
        if (idx < log_q.size()) begin
            chk({tag, "_tid"}, log_q[idx].tid, tid);
            chk({tag, "_data"}, log_q[idx].data, data);
            chk({tag, "_keep"}, log_q[idx].keep, keep);
            chk({tag, "_last"}, log_q[idx].last, last);
        end
    endtask

    function automatic beat_t mk(input logic [31:0] d, input logic [3:0] k, input logic l);
        beat_t b;
        b.data = d; b.keep = k; b.last = l;
        return b;
    endfunction

    int t0;
    int exp_t2[6];
    int exp_t6_tid[5];
    logic [31:0] exp_t6_data[5];

    initial begin
`ifdef AXIS_ARB_FIXED_PRIO_EN
        exp_t2 = '{0, 0, 0, 0, 0, 0};
        exp_t6_tid = '{0, 0, 0, 1, 1};
        exp_t6_data = '{32'h60, 32'h62, 32'h64, 32'h61, 32'h63};
`else
        exp_t2 = '{0, 0, 1, 1, 0, 0};
        exp_t6_tid = '{0, 1, 0, 1, 0};
        exp_t6_data = '{32'h60, 32'h61, 32'h62, 32'h63, 32'h64};
`endif
        present();
        do_reset();
        cmp_en = 1'b1;

        // 1: three-beat packet from source 0, first beat two cycles after valid.
        q0.push_back(mk(32'hA1, 4'hF, 1'b0));
        q0.push_back(mk(32'hA2, 4'hF, 1'b0));
        q0.push_back(mk(32'hA3, 4'hF, 1'b1));
        step();
        t0 = cyc;
        wait_beats(3, 20);
        chk("t1_count", log_q.size(), 3);
        chk_entry("t1_b0", 0, 0, 32'hA1, 4'hF, 1'b0);
        chk_entry("t1_b1", 1, 0, 32'hA2, 4'hF, 1'b0);
        chk_entry("t1_b2", 2, 0, 32'hA3, 4'hF, 1'b1);
        if (log_q.size() == 3) begin
            chk("t1_first_cycle", log_q[0].cyc, t0 + 2);
            chk("t1_last_cycle", log_q[2].cyc, t0 + 4);
        end
        repeat (3) step();

        // 2: both sources busy with two-beat packets.
        do_reset();
        for (int p = 0; p < 3; p++) begin
            q0.push_back(mk(32'h100 + p*2, 4'hF, 1'b0));
            q0.push_back(mk(32'h101 + p*2, 4'hF, 1'b1));
        end
        for (int p = 0; p < 2; p++) begin
            q1.push_back(mk(32'h200 + p*2, 4'hF, 1'b0));
            q1.push_back(mk(32'h201 + p*2, 4'hF, 1'b1));
        end
        step();
        wait_beats(10, 60);
        for (int i = 0; i < 6 && i < log_q.size(); i++) chk("t2_tid", log_q[i].tid, exp_t2[i]);
        if (log_q.size() >= 6) begin
            chk("t2_gap01", log_q[1].cyc - log_q[0].cyc, 1);
            chk("t2_gap12", log_q[2].cyc - log_q[1].cyc, 2);
            chk("t2_gap34", log_q[4].cyc - log_q[3].cyc, 2);
        end
        repeat (3) step();

        // 3: source 0 requests while source 1 holds the lock.
        log_q.delete();
        for (int i = 0; i < 4; i++) q1.push_back(mk(32'h300 + i, 4'hF, i == 3));
        repeat (3) step();
        q0.push_back(mk(32'h310, 4'hF, 1'b0));
        q0.push_back(mk(32'h311, 4'hF, 1'b1));
        chk("t3_src0_blocked", a_tready[0], 1'b0);
        wait_beats(6, 40);
        chk_entry("t3_b3", 3, 1, 32'h303, 4'hF, 1'b1);
        chk_entry("t3_b4", 4, 0, 32'h310, 4'hF, 1'b0);
        chk_entry("t3_b5", 5, 0, 32'h311, 4'hF, 1'b1);
        repeat (3) step();

        // 4: downstream stall, then the source drops valid mid-packet.
        log_q.delete();
        for (int i = 0; i < 4; i++) q0.push_back(mk(32'h400 + i, 4'h5, i == 3));
        step();
        wait_beats(1, 20);
        o_tready = 1'b0;
        repeat (5) step();
        chk("t4_stall_valid", a_tvalid, 1'b1);
        chk("t4_stall_data", a_tdata, 32'h401);
        chk("t4_stall_ready", a_tready, 2'b00);
        o_tready = 1'b1;
        hold[0] = 1'b1;
        present();
        repeat (3) step();
        chk("t4_hold_busy", a_busy, 1'b1);
        hold[0] = 1'b0;
        present();
        wait_beats(4, 40);
        repeat (3) step();
        chk("t4_count", log_q.size(), 4);
        for (int i = 0; i < 4 && i < log_q.size(); i++)
            chk("t4_data", log_q[i].data, 32'h400 + i);

        // 5: reset after the second of four beats.
        for (int i = 0; i < 4; i++) q0.push_back(mk(32'h500 + i, 4'hF, i == 3));
        for (int k = 0; k < 30 && q0.size() > 2; k++) step();
        chk("t5_two_taken", q0.size(), 2);
        rstn = 1'b0;
        #1;
        chk("t5_rst_tvalid", a_tvalid, 1'b0);
        chk("t5_rst_busy", a_busy, 1'b0);
        chk("t5_rst_b_busy", b_busy, 1'b0);
        step();
        step();
        q1.push_back(mk(32'h5F0, 4'hF, 1'b1));
        rstn = 1'b1;
        log_q.delete();
        present();
        wait_beats(3, 30);
        chk_entry("t5_b0", 0, 0, 32'h502, 4'hF, 1'b0);
        chk_entry("t5_b1", 1, 0, 32'h503, 4'hF, 1'b1);
        chk_entry("t5_b2", 2, 1, 32'h5F0, 4'hF, 1'b1);
        repeat (3) step();

        // 6: single-beat packets, partial and empty keep.
        log_q.delete();
        q0.push_back(mk(32'h60, 4'b0011, 1'b1));
        q1.push_back(mk(32'h61, 4'b0011, 1'b1));
        q0.push_back(mk(32'h62, 4'b0011, 1'b1));
        q1.push_back(mk(32'h63, 4'b0011, 1'b1));
        q0.push_back(mk(32'h64, 4'b0000, 1'b1));
        step();
        wait_beats(5, 40);
        for (int i = 0; i < 5 && i < log_q.size(); i++) begin
            chk("t6_tid", log_q[i].tid, exp_t6_tid[i]);
            chk("t6_data", log_q[i].data, exp_t6_data[i]);
            chk("t6_keep", log_q[i].keep, (exp_t6_data[i] == 32'h64) ? 4'b0000 : 4'b0011);
            if (i > 0) chk("t6_gap", log_q[i].cyc - log_q[i-1].cyc, 2);
        end
        repeat (3) step();
        chk("end_sb_empty", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule
